// File: rtl/miner_node_endpoint_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | miner_node_endpoint_pkg
// | Flit layout, status codes and state encodings shared with the controller.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package miner_node_endpoint_pkg;

  localparam int NOC_DATA_W        = 64;
  localparam int NOC_DEST_W        = 5;
  localparam int NOC_VC_W          = 2;
  localparam int NOC_FLIT_W        = 2 + NOC_DATA_W + NOC_DEST_W + NOC_VC_W;
  localparam int NOC_HDR_FLITS     = 10;
  localparam int NUM_VCS           = 4;
  localparam int FLIT_BUFFER_DEPTH = 16;

  localparam logic [63:0] FOUND_MSG     = 64'h1;
  localparam logic [63:0] EXHAUSTED_MSG = 64'h2;

  typedef enum logic [2:0] {
    ST_RECV     = 3'd0,
    ST_HANDOFF  = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_REPLY0   = 3'd3,
    ST_REPLY1   = 3'd4
  } ep_state_e;

  function automatic logic [63:0] status_payload(input logic found);
    return found ? FOUND_MSG : EXHAUSTED_MSG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miner_node_endpoint_credit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | noc_credit_counter
// | Outgoing-credit tracker: preset at reset, +1 per returned credit, -1 per
// | injected flit, clamped to [0, MAX].
// | Revision: 1.0
// +----------------------------------------------------------------------------
module noc_credit_counter #(
  parameter int INIT = 16,
  parameter int MAX  = 16,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             CLK,
  input  logic             nreset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_avail
);

  localparam logic [CNT_W-1:0] C_INIT = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX);

  // A return and an injection in the same cycle cancel out.
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      o_count <= C_INIT;
    end else if (i_inc && !i_dec) begin
      if (o_count != C_MAX) o_count <= o_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (o_count != '0) o_count <= o_count - 1'b1;
    end
  end

  assign o_avail = (o_count != '0);

  always @(posedge CLK) begin
    if (nreset) assert (!(i_inc && !i_dec && o_count == C_MAX));
  end

endmodule
`default_nettype wire

// File: rtl/miner_node_endpoint.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | miner_node_endpoint
// | Worker NoC endpoint: assembles a block header, hands it to the hashing
// | core, and returns a 2-flit status/nonce reply under credit flow control.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module miner_node_endpoint
  import miner_node_endpoint_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = NOC_DATA_W,
  parameter int DEST_BITS       = NOC_DEST_W,
  parameter int VC_BITS         = NOC_VC_W,
  parameter int HDR_FLITS       = NOC_HDR_FLITS,
  parameter int CTRL_NODE_ID    = 0,
  parameter int REPLY_VC        = 0,
  parameter int INIT_CREDITS    = 16,
  localparam int FLIT_W         = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS,
  localparam int HDR_W          = HDR_FLITS * FLIT_DATA_WIDTH
) (
  input  logic                 CLK,
  input  logic                 nreset,
  input  logic [FLIT_W-1:0]    getFlit,
  output logic                 EN_getFlit,
  output logic [VC_BITS:0]     putCredits,
  output logic                 EN_putCredits,
  output logic [FLIT_W-1:0]    putFlit,
  output logic                 EN_putFlit,
  input  logic [VC_BITS:0]     getCredits,
  output logic                 EN_getCredits,
  output logic                 hdr_valid,
  output logic [HDR_W-1:0]     hdr_data,
  input  logic                 hdr_ready,
  input  logic                 res_valid,
  input  logic                 res_found,
  input  logic [31:0]          res_nonce,
  output logic                 res_ready,
  output logic [7:0]           err_count
);

  localparam int VALID_BIT = FLIT_W - 1;
  localparam int TAIL_BIT  = FLIT_W - 2;
  localparam int VC_LSB    = FLIT_DATA_WIDTH;
  localparam int DEST_LSB  = FLIT_DATA_WIDTH + VC_BITS;
  localparam int BEAT_W    = $clog2(HDR_FLITS);
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(HDR_FLITS - 1);
  // A zero-credit start means the controller grants its buffer slots later,
  // so the counter still needs headroom up to the shared buffer depth.
  localparam int CREDIT_CAP = (INIT_CREDITS > 0) ? INIT_CREDITS : FLIT_BUFFER_DEPTH;
  localparam int CRED_W     = $clog2(CREDIT_CAP + 1);

  ep_state_e             r_state, w_state_nxt;
  logic [BEAT_W-1:0]     r_beat, w_beat_nxt;
  logic                  r_live;
  logic                  r_found;
  logic [31:0]           r_nonce;
  logic [7:0]            r_err;
  logic [HDR_W-1:0]      r_hdr;
  logic                  w_accept;
  logic                  w_bad;
  logic                  w_send;
  logic                  w_send_tail;
  logic                  w_credit_avail;
  logic [CRED_W-1:0]     w_out_credits;
  logic [FLIT_DATA_WIDTH-1:0] w_payload;
  logic                  w_unused_ok;

  noc_credit_counter #(
    .INIT (INIT_CREDITS),
    .MAX  (CREDIT_CAP)
  ) u_credits (
    .CLK     (CLK),
    .nreset  (nreset),
    .i_inc   (getCredits[VC_BITS]),
    .i_dec   (w_send),
    .o_count (w_out_credits),
    .o_avail (w_credit_avail)
  );

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_RECV;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_send      = 1'b0;
    w_send_tail = 1'b0;
    EN_getFlit  = 1'b0;
    hdr_valid   = 1'b0;
    res_ready   = 1'b0;
    case (r_state)
      ST_RECV: begin
        EN_getFlit = r_live;
        w_accept   = r_live & getFlit[VALID_BIT];
        if (w_accept) begin
          if (r_beat == C_LAST_BEAT) begin
            w_beat_nxt = '0;
            if (getFlit[TAIL_BIT]) w_state_nxt = ST_HANDOFF;
            else                   w_bad       = 1'b1;
          end else if (getFlit[TAIL_BIT]) begin
            w_beat_nxt = '0;
            w_bad      = 1'b1;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      ST_HANDOFF: begin
        hdr_valid = 1'b1;
        if (hdr_ready) w_state_nxt = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) w_state_nxt = ST_REPLY0;
      end
      ST_REPLY0: begin
        if (w_credit_avail) begin
          w_send      = 1'b1;
          w_state_nxt = ST_REPLY1;
        end
      end
      ST_REPLY1: begin
        if (w_credit_avail) begin
          w_send      = 1'b1;
          w_send_tail = 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      default: w_state_nxt = ST_RECV;
    endcase
  end

  assign w_payload = w_send_tail ? FLIT_DATA_WIDTH'(r_nonce)
                                 : FLIT_DATA_WIDTH'(status_payload(r_found));

  // Credits are returned for every dequeued flit, including ones of a
  // packet that is later dropped, so the upstream buffer never leaks.
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      r_live        <= 1'b0;
      EN_putCredits <= 1'b0;
      putCredits    <= '0;
      EN_putFlit    <= 1'b0;
      putFlit       <= '0;
      r_err         <= '0;
      r_hdr         <= '0;
      r_found       <= 1'b0;
      r_nonce       <= '0;
    end else begin
      r_live        <= 1'b1;
      EN_putCredits <= w_accept;
      putCredits    <= w_accept ? {1'b1, getFlit[VC_LSB +: VC_BITS]} : '0;
      EN_putFlit    <= w_send;
      putFlit       <= w_send ? {1'b1, w_send_tail, DEST_BITS'(CTRL_NODE_ID),
                                 VC_BITS'(REPLY_VC), w_payload} : '0;
      if (w_bad && r_err != 8'hFF) r_err <= r_err + 8'd1;
      if (w_accept) r_hdr[r_beat*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= getFlit[FLIT_DATA_WIDTH-1:0];
      if (r_state == ST_WAIT_RES && res_valid) begin
        r_found <= res_found;
        r_nonce <= res_nonce;
      end
    end
  end

  assign EN_getCredits = r_live;
  assign hdr_data      = r_hdr;
  assign err_count     = r_err;
  assign w_unused_ok   = ^{getFlit[DEST_LSB +: DEST_BITS], getCredits[VC_BITS-1:0]};

endmodule
`default_nettype wire
